serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 23 ++
 rtl/serial_adder_fa.sv | 24 ++
 rtl/serial_adder.sv | 134 +++++++++++++
 tb/tb_serial_adder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
//------------------------------------------------------------------------------
// Module      : serial_adder_pkg
// Description : Shared types and sizing helpers for the bit-serial adder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter must index 0..WIDTH-1 but never collapse to zero bits.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/serial_adder_fa.sv
//------------------------------------------------------------------------------
// Module      : full_adder_bit
// Description : Combinational single-bit full adder cell.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_prop;

    assign w_prop = a ^ b;
    assign sum    = w_prop ^ cin;
    assign cout   = (a & b) | (cin & w_prop);

endmodule : full_adder_bit

`default_nettype wire

// File: rtl/serial_adder.sv
//------------------------------------------------------------------------------
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder, LSB first, one bit per clock,
//               with valid/ready handshakes on operands and result.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sum_shift;

    full_adder_bit u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sum  (fa_s),
        .cout (fa_c)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
    if (WIDTH == 1) begin : g_shift_w1
        assign sum_shift = fa_s;
    end else begin : g_shift_wn
        assign sum_shift = {fa_s, sum_sr_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = sum_shift;
                carry_d  = fa_c;
                // Counter parks at LAST instead of wrapping.
                if (cnt_q == LAST) begin
                    sum_d   = sum_shift;
                    cout_d  = fa_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule : serial_adder

`default_nettype wire

// File: tb/tb_serial_adder.sv
//------------------------------------------------------------------------------
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder (WIDTH 8, 1 and 13).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rst2_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: the result is plain arithmetic, visible W edges after acceptance.
    int         m_phase = 0;
    int         m_rem   = 0;
    logic [W:0] m_res   = '0;
    logic [W:0] m_out   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_rem   = 0;
            m_res   = '0;
            m_out   = '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_res   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                    m_rem   = W;
                    m_phase = 1;
                end
                1: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_out   = m_res;
                        m_phase = 2;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp in_ready",  in_ready,  m_phase == 0);
            chk("cmp out_valid", out_valid, m_phase == 2);
            chk("cmp busy",      busy,      m_phase != 0);
            chk("cmp sum",       sum,       m_out[W-1:0]);
            chk("cmp cout",      cout,      m_out[W]);
        end
    end

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tci,
                      input logic [W-1:0] es, input logic ec, input int bp,
                      input bit disturb, input string tag);
        int lat;
        @(posedge clk); #1;
        a = ta; b = tb_v; cin = tci; in_valid = 1'b1; out_ready = (bp == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (disturb && lat == 2) begin
                a = ~ta; b = 8'hA5; cin = ~tci; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, " latency"}, lat, W);
        chk({tag, " sum"}, sum, es);
        chk({tag, " cout"}, cout, ec);
        if (bp > 0) begin
            for (int i = 0; i < bp; i++) begin
                @(posedge clk); #1;
                chk({tag, " hold out_valid"}, out_valid, 1);
                chk({tag, " hold sum"}, sum, es);
                chk({tag, " hold in_ready"}, in_ready, 0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, " release out_valid"}, out_valid, 0);
        chk({tag, " release in_ready"}, in_ready, 1);
    endtask

    // Independent back-to-back sweeps at the other two widths on their own reset.
    for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
        localparam int SW = (gi == 0) ? 1 : 13;
        logic          s_iv = 1'b0;
        logic          s_ir;
        logic          s_ci = 1'b0;
        logic          s_ov;
        logic          s_co;
        logic          s_bz;
        logic [SW-1:0] s_a = '0;
        logic [SW-1:0] s_b = '0;
        logic [SW-1:0] s_s;
        bit            done_f = 1'b0;

        serial_adder #(.WIDTH(SW)) u_sw (
            .clk       (clk),
            .rst_n     (rst2_n),
            .in_valid  (s_iv),
            .in_ready  (s_ir),
            .a         (s_a),
            .b         (s_b),
            .cin       (s_ci),
            .out_valid (s_ov),
            .out_ready (1'b1),
            .sum       (s_s),
            .cout      (s_co),
            .busy      (s_bz)
        );

        initial begin
            logic [SW:0] e;
            int          lat;
            wait (rst2_n === 1'b1);
            for (int n = 0; n < 1000; n++) begin
                @(posedge clk); #1;
                chk($sformatf("w%0d in_ready", SW), s_ir, 1);
                s_a  = SW'($urandom);
                s_b  = SW'($urandom);
                s_ci = 1'($urandom);
                s_iv = 1'b1;
                e    = {1'b0, s_a} + {1'b0, s_b} + {{SW{1'b0}}, s_ci};
                @(posedge clk); #1;
                s_iv = 1'b0;
                chk($sformatf("w%0d busy", SW), s_bz, 1);
                lat = 0;
                while (!s_ov && lat < 100) begin
                    @(posedge clk); #1;
                    lat++;
                end
                chk($sformatf("w%0d latency", SW), lat, SW);
                chk($sformatf("w%0d sum", SW), s_s, e[SW-1:0]);
                chk($sformatf("w%0d cout", SW), s_co, e[SW]);
                @(posedge clk); #1;
            end
            done_f = 1'b1;
        end
    end

    initial begin
        logic [W:0] e;
        logic [W-1:0] ra, rb;
        logic rc;
        bit all_done;

        @(posedge clk); #1;
        chk("reset in_ready",  in_ready,  1);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy",      busy,      0);
        chk("reset sum",       sum,       0);
        chk("reset cout",      cout,      0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        cmp_en = 1'b1;

        op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 0, 1'b0, "5A+33");
        op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0, "FF+01");
        op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 1'b0, "FF+FF+1");
        op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 5, 1'b0, "backpressure");
        op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 0, 1'b1, "ignore");

        // Abandon an operation part way through RUN.
        @(posedge clk); #1;
        a = 8'h5A; b = 8'h33; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun in_ready",  in_ready,  1);
        chk("midrun out_valid", out_valid, 0);
        chk("midrun busy",      busy,      0);
        chk("midrun sum",       sum,       0);
        chk("midrun cout",      cout,      0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        op(8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 0, 1'b0, "after reset");

        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            e  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            op(ra, rb, rc, e[W-1:0], e[W], 0, 1'b0, "w8 sweep");
        end

        all_done = 1'b0;
        for (int k = 0; k < 40000 && !all_done; k++) begin
            @(posedge clk);
            all_done = g_sweep[0].done_f && g_sweep[1].done_f;
        end
        chk("sweeps finished", all_done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_adder

`default_nettype wire
